// File: rtl/systolic_mem_responder_pkg.sv
// Shared types for the systolic core's memory-side responder: FSM state encoding,
// read-latency bound and a saturating counter helper.
package systolic_mem_responder_pkg;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_READ = 2'd1,
    MR_RESP = 2'd2
  } mem_rsp_state_t;

  localparam int MEM_RD_LAT_MAX = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/systolic_mem_array.sv
// Single-port DEPTH x WIDTH data RAM; write commits on the enabled edge, read data is
// registered one cycle later and holds until the next enabled read. No flow control.
module systolic_mem_array #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [IDX_W-1:0]        addr,
  input  logic signed [WIDTH-1:0] wdata,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/systolic_mem_responder.sv
// One-outstanding read/write responder: read response RD_LAT cycles after accept, write/error 1 cycle;
// req_ready drops from accept through the response cycle, the response itself cannot be stalled.
module systolic_mem_responder
  import systolic_mem_responder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic signed [WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic signed [WIDTH-1:0] rsp_rdata,
  output logic                    rsp_error,
  output logic [31:0]             reads_count,
  output logic [31:0]             writes_count,
  output mem_rsp_state_t          rsp_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
  localparam int TAP = (RD_LAT >= 3) ? RD_LAT - 3 : 0;

  mem_rsp_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic accept, in_range, rd_hit;
  logic err_q, rd_flag_q;
  logic signed [WIDTH-1:0] rdata_q, ram_q, tap;
  logic signed [WIDTH-1:0] dly [MEM_RD_LAT_MAX-2];
  logic [31:0] reads_q, writes_q;

  assign in_range = ({1'b0, req_addr} < DEPTH_V);
  assign accept   = req_valid && (state_q == MR_IDLE);
  assign rd_hit   = accept && in_range && !req_write;

  systolic_mem_array #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (accept && in_range),
    .we   (req_write),
    .addr (req_addr[IDX_W-1:0]),
    .wdata(req_wdata),
    .rdata(ram_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MR_IDLE: begin
        if (accept) begin
          if (rd_hit && RD_LAT > 1) begin
            state_d = MR_READ;
            cnt_d   = LAT_INIT;
          end else begin
            state_d = MR_RESP;
          end
        end
      end
      MR_READ: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = MR_RESP;
      end
      MR_RESP: state_d = MR_IDLE;
      default: state_d = MR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MR_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM output is already one stage; dly supplies the remaining stages beyond rdata_q.
  always_ff @(posedge clk) begin
    dly[0] <= ram_q;
    for (int i = 1; i < MEM_RD_LAT_MAX - 2; i++) dly[i] <= dly[i-1];
  end

  assign tap = (RD_LAT >= 3) ? dly[TAP] : ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      rd_flag_q <= 1'b0;
      rdata_q   <= '0;
      reads_q   <= 32'd0;
      writes_q  <= 32'd0;
    end else begin
      if (accept) begin
        err_q     <= !in_range;
        rd_flag_q <= rd_hit;
        if (!rd_hit) rdata_q <= '0;
        if (rd_hit) reads_q <= sat_inc(reads_q);
        if (in_range && req_write) writes_q <= sat_inc(writes_q);
      end
      if (state_q == MR_READ && cnt_q == 2'd1) rdata_q <= tap;
    end
  end

  // With RD_LAT=1 the RAM output register is the response register.
  assign rsp_rdata    = (RD_LAT == 1) ? (rd_flag_q ? ram_q : '0) : rdata_q;
  assign rsp_error    = err_q;
  assign rsp_valid    = (state_q == MR_RESP);
  assign req_ready    = (state_q == MR_IDLE);
  assign rsp_state    = state_q;
  assign reads_count  = reads_q;
  assign writes_count = writes_q;

endmodule

// File: tb/tb_systolic_mem_responder.sv
// Bench for systolic_mem_responder: four instances (RD_LAT 1..4, DEPTH 48) driven from request
// queues and checked every cycle against a transaction-level model of memory, timing and counters.
module tb_systolic_mem_responder;
  import systolic_mem_responder_pkg::*;

  localparam int N = 4;
  localparam int W = 16;
  localparam int AW = 12;
  localparam int D = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                req_valid [N];
  logic                req_ready [N];
  logic                req_write [N];
  logic [AW-1:0]       req_addr  [N];
  logic signed [W-1:0] req_wdata [N];
  logic                rsp_valid [N];
  logic signed [W-1:0] rsp_rdata [N];
  logic                rsp_error [N];
  logic [31:0]         reads_count [N];
  logic [31:0]         writes_count [N];
  mem_rsp_state_t      rsp_state [N];

  for (genvar k = 0; k < N; k++) begin : g_dut
    systolic_mem_responder #(
      .WIDTH(W), .ADDR_W(AW), .DEPTH(D), .RD_LAT(k + 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[k]), .req_ready(req_ready[k]), .req_write(req_write[k]),
      .req_addr(req_addr[k]), .req_wdata(req_wdata[k]),
      .rsp_valid(rsp_valid[k]), .rsp_rdata(rsp_rdata[k]), .rsp_error(rsp_error[k]),
      .reads_count(reads_count[k]), .writes_count(writes_count[k]), .rsp_state(rsp_state[k])
    );
  end

  typedef struct {
    logic                wr;
    logic [AW-1:0]       addr;
    logic signed [W-1:0] wdata;
  } req_t;

  typedef struct {
    int                  due;
    logic signed [W-1:0] data;
    logic                err;
  } rsp_t;

  req_t rq[$];
  rsp_t eq[$];
  logic signed [W-1:0] mem_m [N][D];
  logic [31:0] rd_m [N];
  logic [31:0] wr_m [N];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic push(input logic wr, input int addr, input int wdata);
    req_t r;
    r.wr = wr;
    r.addr = AW'(addr);
    r.wdata = W'(wdata);
    rq.push_back(r);
  endtask

  // Drains rq into instance k; hold=1 keeps req_valid high whenever work remains.
  task automatic run(input int k, input bit hold, input int max_cycles);
    int cyc = 0;
    bit pend = 0;
    bit acc, exp_ready;
    req_t cur;
    mem_rsp_state_t exp_state;
    rsp_t r;
    cur.wr = 0; cur.addr = '0; cur.wdata = '0;
    while ((rq.size() > 0 || pend || eq.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      exp_ready = (eq.size() == 0);
      exp_state = exp_ready ? MR_IDLE : (eq[0].due == cyc ? MR_RESP : MR_READ);
      chk("ready", req_ready[k], exp_ready);
      chk("state", rsp_state[k], exp_state);
      chk("reads_count", reads_count[k], rd_m[k]);
      chk("writes_count", writes_count[k], wr_m[k]);
      if (eq.size() > 0 && eq[0].due == cyc) begin
        chk("rsp_valid", rsp_valid[k], 1'b1);
        chk("rsp_rdata", rsp_rdata[k], eq[0].data);
        chk("rsp_error", rsp_error[k], eq[0].err);
        void'(eq.pop_front());
      end else begin
        chk("rsp_idle", rsp_valid[k], 1'b0);
      end
      if (!pend && rq.size() > 0 && (hold || $urandom_range(0, 2) != 0)) begin
        cur = rq.pop_front();
        pend = 1;
      end
      req_valid[k] = pend;
      req_write[k] = cur.wr;
      req_addr[k]  = cur.addr;
      req_wdata[k] = cur.wdata;
      acc = pend && exp_ready;
      @(posedge clk);
      cyc++;
      if (acc) begin
        pend = 0;
        r.err = (int'(cur.addr) >= D);
        r.data = '0;
        r.due = cyc + ((r.err || cur.wr) ? 1 : k + 1) - 1;
        if (!r.err) begin
          if (cur.wr) begin
            mem_m[k][int'(cur.addr)] = cur.wdata;
            wr_m[k] = sat(wr_m[k]);
          end else begin
            r.data = mem_m[k][int'(cur.addr)];
            rd_m[k] = sat(rd_m[k]);
          end
        end
        eq.push_back(r);
      end
    end
    chk("drain", 64'(rq.size() + eq.size() + int'(pend)), 64'd0);
    rq.delete();
    eq.delete();
    req_valid[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 0; req_write[k] = 0; req_addr[k] = '0; req_wdata[k] = '0;
      rd_m[k] = 0; wr_m[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_ready", req_ready[k], 1'b1);
      chk("rst_valid", rsp_valid[k], 1'b0);
      chk("rst_rdata", rsp_rdata[k], '0);
      chk("rst_error", rsp_error[k], 1'b0);
      chk("rst_reads", reads_count[k], 32'd0);
      chk("rst_writes", writes_count[k], 32'd0);
      chk("rst_state", rsp_state[k], MR_IDLE);
    end
    rst = 1'b0;

    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < D; a++) push(1, a, a);
      run(k, 1, 400);
    end

    // Reset while instance 1 (RD_LAT=2) is in MR_READ
    @(negedge clk);
    req_valid[1] = 1; req_write[1] = 0; req_addr[1] = 12'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 0;
    chk("mid_state", rsp_state[1], MR_READ);
    rst = 1'b1;
    #1;
    chk("arst_state", rsp_state[1], MR_IDLE);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin rd_m[k] = 0; wr_m[k] = 0; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid[1], 1'b0);
    end
    chk("rst_mid_reads", reads_count[1], 32'd0);

    push(1, 5, -123);
    push(0, 5, 0);
    run(1, 1, 50);
    chk("dir_reads", reads_count[1], 32'd1);
    chk("dir_writes", writes_count[1], 32'd1);

    push(1, 5, 5);
    for (int a = 0; a < 16; a++) push(0, a, 0);
    run(1, 1, 200);

    push(0, 48, 0);
    push(1, 100, 777);
    push(0, 4, 0);
    run(1, 1, 50);

    for (int k = 0; k < N; k++) begin
      push(1, 7, $urandom_range(0, 65535));
      push(0, 7, 0);
      for (int i = 0; i < 40; i++)
        push($urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? 4095 : $urandom_range(0, 55),
             $urandom_range(0, 65535));
      run(k, i_bit(k), 1500);
    end

    @(negedge clk);
    force g_dut[1].u_dut.reads_q = 32'hFFFF_FFFE;
    #1;
    release g_dut[1].u_dut.reads_q;
    rd_m[1] = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) push(0, i, 0);
    run(1, 1, 50);
    chk("sat_reads", reads_count[1], 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic bit i_bit(input int k);
    return bit'(k & 1);
  endfunction

endmodule
